// File: rtl/scr1_tcm_portb_arb.sv
// Port-B arbiter/sequencer for the dual-port TCM: shares one 1-cycle synchronous port between LSU (r0) and system bus (r1).
// Build option: define SCR1_TCM_ARB_RR_EN for round-robin arbitration; default is fixed priority with an r1 starvation guard.

module scr1_tcm_portb_arb #(
  parameter int unsigned SCR1_SIZE       = 32'h00010000,
  parameter int unsigned SCR1_DWIDTH     = 64,
  parameter int unsigned SCR1_DBYTES     = SCR1_DWIDTH / 8,
  parameter int unsigned SCR1_STARVE_LIM = 4,
  localparam int unsigned AW             = $clog2(SCR1_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // requester 0 (LSU)
  input  logic                   r0_req,
  input  logic                   r0_we,
  input  logic [AW-1:3]          r0_addr,
  input  logic [SCR1_DBYTES-1:0] r0_be,
  input  logic [SCR1_DWIDTH-1:0] r0_wdata,
  output logic                   r0_ack,
  output logic                   r0_resp,
  output logic [SCR1_DWIDTH-1:0] r0_rdata,
  // requester 1 (DMA / debug system bus)
  input  logic                   r1_req,
  input  logic                   r1_we,
  input  logic [AW-1:3]          r1_addr,
  input  logic [SCR1_DBYTES-1:0] r1_be,
  input  logic [SCR1_DWIDTH-1:0] r1_wdata,
  output logic                   r1_ack,
  output logic                   r1_resp,
  output logic [SCR1_DWIDTH-1:0] r1_rdata,
  // memory port B
  output logic                   renb,
  output logic                   wenb,
  output logic [SCR1_DBYTES-1:0] webb,
  output logic [AW-1:3]          addrb,
  output logic [SCR1_DWIDTH-1:0] datab,
  input  logic [SCR1_DWIDTH-1:0] qb
);

  logic w_r1_pri;   // r1 wins a conflict this cycle
  logic w_gnt0;
  logic w_gnt1;
  logic w_rd_gnt;

  logic r_resp_vld;
  logic r_resp_own;
  logic r_resp_rd;

`ifdef SCR1_TCM_ARB_RR_EN
  logic r_last_gnt;

  // The requester that did not win the previous grant wins the next conflict.
  assign w_r1_pri = ~r_last_gnt;

  // Reset value 1 makes requester 0 the preferred one after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (w_gnt0 | w_gnt1) begin
      r_last_gnt <= w_gnt1;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(SCR1_STARVE_LIM);

  logic [3:0] r_starve_cnt;

  assign w_r1_pri = (r_starve_cnt == STARVE_LIM);

  // Counts consecutive denied r1 cycles; a dropped request or a grant restarts the count.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (!r1_req || w_gnt1) begin
      r_starve_cnt <= 4'd0;
    end else begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`endif

  // NOTE: every output of this always_comb is given a default first, so no latch is inferred.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      w_gnt1 = r1_req & (~r0_req | w_r1_pri);
      w_gnt0 = r0_req & ~w_gnt1;
    end
  end

  assign w_rd_gnt = (w_gnt0 & ~r0_we) | (w_gnt1 & ~r1_we);

  assign r0_ack = w_gnt0;
  assign r1_ack = w_gnt1;

  assign renb  = w_rd_gnt;
  assign wenb  = (w_gnt0 & r0_we) | (w_gnt1 & r1_we);
  assign addrb = w_gnt1 ? r1_addr  : r0_addr;
  assign webb  = w_gnt1 ? r1_be    : r0_be;
  assign datab = w_gnt1 ? r1_wdata : r0_wdata;

  // Response pipe: reloaded every cycle; an async reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_vld <= 1'b0;
      r_resp_own <= 1'b0;
      r_resp_rd  <= 1'b0;
    end else begin
      r_resp_vld <= w_gnt0 | w_gnt1;
      r_resp_own <= w_gnt1;
      r_resp_rd  <= w_rd_gnt;
    end
  end

  assign r0_resp  = r_resp_vld & ~r_resp_own;
  assign r1_resp  = r_resp_vld &  r_resp_own;
  assign r0_rdata = r_resp_rd ? qb : '0;
  assign r1_rdata = r_resp_rd ? qb : '0;

endmodule

// File: tb/tb_scr1_tcm_portb_arb.sv
// Self-checking bench for scr1_tcm_portb_arb: directed steps plus random traffic against a transaction-level model.
// Build with SCR1_TCM_ARB_RR_EN defined to check the round-robin variant.

module tb_scr1_tcm_portb_arb;

  localparam int AWD = 13;   // doubleword address width for a 64 KiB TCM
  localparam int DW  = 64;
  localparam int DB  = 8;
  localparam int LIM = 4;

  typedef struct packed {
    logic            req;
    logic            we;
    logic [AWD-1:0]  addr;
    logic [DB-1:0]   be;
    logic [DW-1:0]   data;
  } req_t;

  logic            clk;
  logic            rst_n;
  logic            r0_req, r0_we, r0_ack, r0_resp;
  logic [AWD-1:0]  r0_addr;
  logic [DB-1:0]   r0_be;
  logic [DW-1:0]   r0_wdata, r0_rdata;
  logic            r1_req, r1_we, r1_ack, r1_resp;
  logic [AWD-1:0]  r1_addr;
  logic [DB-1:0]   r1_be;
  logic [DW-1:0]   r1_wdata, r1_rdata;
  logic            renb, wenb;
  logic [DB-1:0]   webb;
  logic [AWD-1:0]  addrb;
  logic [DW-1:0]   datab;
  logic [DW-1:0]   qb;

  int n_tests = 0;
  int n_fail  = 0;

  scr1_tcm_portb_arb dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_be(r0_be), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_resp(r0_resp), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_be(r1_be), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_resp(r1_resp), .r1_rdata(r1_rdata),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B memory: byte-enabled write, registered read.
  logic [DW-1:0] mem [logic [AWD-1:0]];
  logic [DW-1:0] mem_cur;
  always @(posedge clk) begin
    if (wenb) begin
      mem_cur = mem.exists(addrb) ? mem[addrb] : '0;
      for (int b = 0; b < DB; b++)
        if (webb[b]) mem_cur[b*8 +: 8] = datab[b*8 +: 8];
      mem[addrb] = mem_cur;
    end
    if (renb) qb <= mem.exists(addrb) ? mem[addrb] : '0;
  end

  // Transaction-level reference model state.
  logic [DW-1:0] ref_mem [int];
  bit            exp_vld, exp_own, exp_rd;
  logic [DW-1:0] exp_data;
  int            starve;       // consecutive cycles r1 has been refused
  int            last_winner;  // requester granted most recently

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_get(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic req_t mk(input bit q, input bit w, input int a, input logic [DB-1:0] be,
                              input logic [DW-1:0] d);
    req_t r;
    r.req = q; r.we = w; r.addr = AWD'(a); r.be = be; r.data = d;
    return r;
  endfunction

  function automatic req_t idle();
    return mk(0, 0, 0, '0, '0);
  endfunction

  function automatic req_t rd(input int a);
    return mk(1, 0, a, '0, '0);
  endfunction

  function automatic req_t wr(input int a, input logic [DB-1:0] be, input logic [DW-1:0] d);
    return mk(1, 1, a, be, d);
  endfunction

  task automatic model_reset();
    exp_vld = 0; exp_own = 0; exp_rd = 0; exp_data = '0;
    starve = 0;
    last_winner = 1;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input req_t a, input req_t b, output bit go0, output bit go1);
    bit   pri1, g0, g1;
    req_t w;
    logic [DW-1:0] v;
    @(negedge clk);
    r0_req = a.req; r0_we = a.we; r0_addr = a.addr; r0_be = a.be; r0_wdata = a.data;
    r1_req = b.req; r1_we = b.we; r1_addr = b.addr; r1_be = b.be; r1_wdata = b.data;
    #1;
    check("r0_resp", r0_resp, exp_vld && !exp_own);
    check("r1_resp", r1_resp, exp_vld && exp_own);
    if (exp_vld) begin
      if (exp_own) check("r1_rdata", r1_rdata, exp_rd ? exp_data : '0);
      else         check("r0_rdata", r0_rdata, exp_rd ? exp_data : '0);
    end
`ifdef SCR1_TCM_ARB_RR_EN
    pri1 = (last_winner == 0);
`else
    pri1 = (starve >= LIM);
`endif
    g1 = b.req && (!a.req || pri1);
    g0 = a.req && !g1;
    w  = g1 ? b : a;
    check("r0_ack", r0_ack, g0);
    check("r1_ack", r1_ack, g1);
    check("renb", renb, (g0 || g1) && !w.we);
    check("wenb", wenb, (g0 || g1) && w.we);
    if (g0 || g1) begin
      check("addrb", addrb, w.addr);
      if (w.we) begin
        check("webb", webb, w.be);
        check("datab", datab, w.data);
      end
    end
    exp_vld = g0 || g1;
    exp_own = g1;
    exp_rd  = exp_vld && !w.we;
    if (exp_rd) exp_data = ref_get(w.addr);
    if (exp_vld && w.we) begin
      v = ref_get(w.addr);
      for (int i = 0; i < DB; i++)
        if (w.be[i]) v[i*8 +: 8] = w.data[i*8 +: 8];
      ref_mem[w.addr] = v;
    end
    if (!b.req || g1) starve = 0;
    else              starve++;
    if (g0 || g1) last_winner = g1 ? 1 : 0;
    go0 = g0; go1 = g1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_r0_ack"}, r0_ack, 1'b0);
    check({tag, "_r1_ack"}, r1_ack, 1'b0);
    check({tag, "_renb"}, renb, 1'b0);
    check({tag, "_wenb"}, wenb, 1'b0);
    check({tag, "_r0_resp"}, r0_resp, 1'b0);
    check({tag, "_r1_resp"}, r1_resp, 1'b0);
    check({tag, "_r0_rdata"}, r0_rdata, '0);
    check({tag, "_r1_rdata"}, r1_rdata, '0);
  endtask

  initial begin
    bit   g0, g1;
    req_t p0, p1;
    bit   exp_r1;

    // Reset state, with a request applied to prove grants are suppressed.
    rst_n = 1'b0;
    {r0_req, r0_we, r0_addr, r0_be, r0_wdata} = '0;
    {r1_req, r1_we, r1_addr, r1_be, r1_wdata} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    r0_req = 1'b1;
    #1;
    check_all_zero("rst");
    r0_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read back on the next cycle.
    step(wr(16, 8'hFF, 64'h1122334455667788), idle(), g0, g1);
    step(rd(16), idle(), g0, g1);
    step(idle(), idle(), g0, g1);
    check("t1_r0_rdata", r0_rdata, 64'h1122334455667788);
    check("t1_r1_resp", r1_resp, 1'b0);

    // Back-to-back reads with no bubbles.
    step(wr(0, 8'hFF, 64'hA0A0_0000_0000_0000), idle(), g0, g1);
    step(wr(1, 8'hFF, 64'hB1B1_1111_1111_1111), idle(), g0, g1);
    step(wr(2, 8'hFF, 64'hC2C2_2222_2222_2222), idle(), g0, g1);
    step(rd(0), idle(), g0, g1);
    step(rd(1), idle(), g0, g1);
    check("b2b_resp0", r0_resp, 1'b1);
    check("b2b_data0", r0_rdata, 64'hA0A0_0000_0000_0000);
    step(rd(2), idle(), g0, g1);
    check("b2b_data1", r0_rdata, 64'hB1B1_1111_1111_1111);
    step(idle(), idle(), g0, g1);
    check("b2b_data2", r0_rdata, 64'hC2C2_2222_2222_2222);

    // Lone r1 access so the round-robin pointer favours r0 at the first conflict.
    step(idle(), rd(3), g0, g1);

    // Continuous conflict.
    for (int i = 0; i < 10; i++) begin
      step(rd(i), rd(i + 100), g0, g1);
`ifdef SCR1_TCM_ARB_RR_EN
      exp_r1 = (i % 2) == 1;
`else
      exp_r1 = (i % (LIM + 1)) == LIM;
`endif
      check("conflict_r1_ack", r1_ack, exp_r1);
    end

    // Partial write by r1.
    step(idle(), wr(40, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF), g0, g1);
    step(idle(), wr(40, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB), g0, g1);
    step(idle(), rd(40), g0, g1);
    step(idle(), idle(), g0, g1);
    check("be_r1_rdata", r1_rdata, 64'hFFFF_FFFF_BBBB_BBBB);

    // r1 read granted, then reset before the next edge: the response must vanish.
    step(idle(), rd(40), g0, g1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    {r0_req, r1_req} = 2'b00;
    @(posedge clk);
    #1;
    check_all_zero("midrst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // First conflict after reset goes to r0; then a drop restarts the starvation count.
    step(rd(1), rd(2), g0, g1);
    check("post_rst_r0_ack", r0_ack, 1'b1);
    step(rd(1), rd(2), g0, g1);
    step(rd(1), idle(), g0, g1);
    for (int j = 0; j < 6; j++) begin
      step(rd(j), rd(j + 8), g0, g1);
`ifdef SCR1_TCM_ARB_RR_EN
      exp_r1 = (j % 2) == 0;
`else
      exp_r1 = (j == LIM);
`endif
      check("drop_r1_ack", r1_ack, exp_r1);
    end

    // Random traffic honouring hold-until-ack, with occasional cancellation.
    p0 = idle();
    p1 = idle();
    for (int k = 0; k < 400; k++) begin
      if (!p0.req) begin
        if ($urandom_range(0, 9) < 6)
          p0 = mk(1, $urandom_range(0, 1) == 1, $urandom_range(0, 7), 8'($urandom), {$urandom, $urandom});
      end else if ($urandom_range(0, 9) == 0) begin
        p0 = idle();
      end
      if (!p1.req) begin
        if ($urandom_range(0, 9) < 6)
          p1 = mk(1, $urandom_range(0, 1) == 1, $urandom_range(0, 7), 8'($urandom), {$urandom, $urandom});
      end else if ($urandom_range(0, 9) == 0) begin
        p1 = idle();
      end
      step(p0, p1, g0, g1);
      if (g0) p0 = idle();
      if (g1) p1 = idle();
    end
    step(idle(), idle(), g0, g1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scr1_tcm_portb_arb.md
# scr1_tcm_portb_arb

Two-requester arbiter and sequencer for port B of the dual-port TCM (64-bit, byte-enabled, 1-cycle synchronous read). It shares port B between the core data interface (requester 0, LSU) and a DMA/debug system-bus interface (requester 1). It returns read data and write completions to the granted requester. Port A (instruction fetch) is not touched.

## Interface
- `SCR1_SIZE`, default `32'h00010000`: TCM size in bytes; address width is `AW = $clog2(SCR1_SIZE)`.
- `SCR1_DWIDTH`, default 64: data width.
- `SCR1_DBYTES`, default `SCR1_DWIDTH/8`: byte-enable width.
- `SCR1_STARVE_LIM`, default 4: consecutive denied cycles after which the loser is force-granted (fixed-priority mode only); range 1..15.

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous active-low reset
- `r0_req`  in  1  requester 0 request
- `r0_we`  in  1  requester 0: 1 write, 0 read
- `r0_addr`  in  AW-3  requester 0 doubleword address [AW-1:3]
- `r0_be`  in  DBYTES  requester 0 byte enables (writes)
- `r0_wdata`  in  DWIDTH  requester 0 write data
- `r0_ack`  out  1  requester 0 request accepted this cycle
- `r0_resp`  out  1  requester 0 response valid (1-cycle pulse)
- `r0_rdata`  out  DWIDTH  requester 0 read data, valid with `r0_resp` on reads
- `r1_*`  same set as r0, for requester 1
- `renb`, `wenb`  out  1  memory port B read/write enables
- `webb`  out  DBYTES  memory byte enables
- `addrb`  out  AW-3  memory address
- `datab`  out  DWIDTH  memory write data
- `qb`  in  DWIDTH  memory read data

## Operation
- Single-beat requests. Each request is a read or a write, never both.
- Grant is combinational within the cycle. `rN_ack` = grant to N. The granted requester's fields drive `addrb`/`datab`/`webb`. `renb` = grant & !we. `wenb` = grant & we.
- With no request, all memory enables are 0. `addrb`/`datab`/`webb` hold requester 0's values; they are don't-care when the enables are 0.
- Requester holds `req` and its fields stable until `ack`. Dropping `req` before `ack` is legal and cancels the request.
- Response pipeline register: `resp_vld`, `resp_own`, `resp_rd`, loaded every cycle from the current grant.
  - `rN_resp` = `resp_vld & (resp_own==N)`.
  - `rN_rdata` = `qb` when `resp_rd`, else 0.
- Back-to-back grants every cycle are allowed. There is no outstanding-transaction limit beyond the 1-deep response pipe.
- Fixed-priority mode (default): requester 0 wins on conflict.
  - Starvation counter `starve_cnt` (4 bits): increments when r1 requests and is denied. Clears when r1 is granted or r1 drops `req`.
  - When `starve_cnt == SCR1_STARVE_LIM`, r1 wins the next conflict. The counter then clears.
- Read-during-write to the same address across consecutive cycles: the write lands first, so the next-cycle read returns new data. No forwarding is done in this block.

## Timing
- Request accept: same cycle as `req` when granted.
- Read: granted in cycle T; `qb`/`rN_rdata` and `rN_resp` valid in T+1.
- Write: memory updates at the T→T+1 edge; `rN_resp` pulses in T+1 with `rdata` = 0.
- Reset (async assert, sync deassert expected upstream): `resp_vld`=0, `resp_own`=0, `resp_rd`=0, `starve_cnt`=0, RR pointer → requester 0 preferred.
  - All `rN_resp`=0 and `rN_rdata`=0 during reset.
  - `rN_ack` and memory enables are forced 0 while `rst_n`=0.
- Reset mid-operation: a pending response is dropped with no pulse. The requester must reissue.

## Configuration
- `SCR1_TCM_ARB_RR_EN` defined: round-robin arbitration.
  - 1-bit `last_gnt` register. On conflict, the requester not granted last wins. `last_gnt` updates on every grant.
  - Starvation counter and `SCR1_STARVE_LIM` are unused and not instantiated.
- Not defined: fixed priority with the starvation counter, as described above.

## Test plan
- r0 write addr 0x10, be 0xFF, data 0x1122334455667788; next cycle r0 read 0x10 → `r0_ack` both cycles; read `r0_resp` one cycle later with `r0_rdata` = 0x1122334455667788; `r1_resp` stays 0.
- r0 and r1 continuously request reads (fixed priority, LIM=4) → r0 acked 4 cycles, r1 acked on the 5th conflict, then r0 again; RR build: strict alternation r0, r1, r0, …
- r1 write with be 0x0F, data 0xAAAAAAAABBBBBBBB over 0xFFFFFFFFFFFFFFFF, then r1 read → `r1_rdata` = 0xFFFFFFFFBBBBBBBB.
- Back-to-back r0 reads of 0x0, 0x1, 0x2 on consecutive cycles → three consecutive `r0_resp` pulses with matching data, no bubbles.
- r1 read granted, then `rst_n` pulled low before the next edge → no `r1_resp`; all outputs 0 during reset; first conflict after release goes to r0.
- r1 asserts `req` for 2 cycles, drops it, reasserts → `starve_cnt` back at 0; four more denials needed before the force-grant.
